// File: rtl/cla32_clk.sv
// Two-stage registered 32-bit carry-lookahead adder: {co,s} = a + b + ci.
// Define CLA32_OVF_EN to add the registered signed-overflow output ov.
module cla32_clk (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] s,
  output logic        co
`ifdef CLA32_OVF_EN
  ,
  output logic        ov
`endif
);

  // No handshake: both stages load unconditionally on every rising edge,
  // so a result leaves the pipe exactly two edges after its operands arrive.
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        ci_q, ci_d;
  logic [31:0] s_q, s_d;
  logic        co_q, co_d;

  logic [31:0] g, p;
  logic [7:0]  grp_g, grp_p;
  logic [8:0]  gc;
  logic [32:0] c;
  logic [31:0] s_next;

  assign g = a_q & b_q;
  assign p = a_q ^ b_q;

  // Group generate/propagate for each 4-bit block.
  always_comb begin
    grp_g = '0;
    grp_p = '0;
    for (int k = 0; k < 8; k++) begin
      grp_g[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      grp_p[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
    end
  end

  // Second-level lookahead: each group carry is a flat sum of products
  // over the lower groups' G/P and ci, never a chain through gc itself.
  always_comb begin
    logic term;
    logic prod;
    gc    = '0;
    gc[0] = ci_q;
    term  = 1'b0;
    prod  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      term = grp_g[k];
      prod = grp_p[k];
      for (int j = 6; j >= 0; j--) begin
        if (j < k) begin
          term = term | (prod & grp_g[j]);
          prod = prod & grp_p[j];
        end
      end
      gc[k+1] = term | (prod & ci_q);
    end
  end

  // Intra-group carries from the group carry-in using lookahead equations.
  always_comb begin
    c = '0;
    for (int k = 0; k < 8; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
               | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
    c[32] = gc[8];
  end

  assign s_next = p ^ c[31:0];

  always_comb begin
    a_d  = a;
    b_d  = b;
    ci_d = ci;
    s_d  = s_next;
    co_d = c[32];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q  <= '0;
      b_q  <= '0;
      ci_q <= 1'b0;
      s_q  <= '0;
      co_q <= 1'b0;
    end else begin
      a_q  <= a_d;
      b_q  <= b_d;
      ci_q <= ci_d;
      s_q  <= s_d;
      co_q <= co_d;
    end
  end

  assign s  = s_q;
  assign co = co_q;

`ifdef CLA32_OVF_EN
  logic ov_q, ov_d;

  always_comb begin
    ov_d = (a_q[31] == b_q[31]) && (s_next[31] != a_q[31]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ov_q <= 1'b0;
    else          ov_q <= ov_d;
  end

  assign ov = ov_q;
`endif

endmodule

// File: tb/tb_cla32_clk.sv
// Bench for cla32_clk: directed vector table, reset corner cases and
// random vectors checked against an integer-arithmetic reference.
module tb_cla32_clk;

  logic        clk;
  logic        reset_n;
  logic [31:0] a, b;
  logic        ci;
  logic [31:0] s;
  logic        co;
`ifdef CLA32_OVF_EN
  logic        ov;
`endif

  int total = 0;
  int bad   = 0;

  // Expected entry packing: {ov, co, s}
  logic [33:0] exp_q[$];
  string       name_q[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic [31:0] s;
    logic        co;
    logic        ov;
    string       name;
  } vec_t;

  vec_t vecs[10];

  cla32_clk dut (
    .clk     (clk),
    .reset_n (reset_n),
    .a       (a),
    .b       (b),
    .ci      (ci),
    .s       (s),
    .co      (co)
`ifdef CLA32_OVF_EN
    ,
    .ov      (ov)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [33:0] ref_add(input logic [31:0] ra, input logic [31:0] rb,
                                          input logic rci);
    longint unsigned u;
    longint          sv;
    logic [31:0]     rs;
    logic            rco;
    logic            rov;
    u   = longint'(ra) + longint'(rb) + longint'(rci);
    rs  = u[31:0];
    rco = u[32];
    sv  = longint'($signed(ra)) + longint'($signed(rb)) + longint'(rci);
    rov = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
    return {rov, rco, rs};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check_out(input string nm, input logic [33:0] e);
    total++;
    if ({co, s} !== e[32:0]) begin
      bad++;
      $display("FAIL %s: got co=%0b s=%08h, expected co=%0b s=%08h",
               nm, co, s, e[32], e[31:0]);
    end
`ifdef CLA32_OVF_EN
    total++;
    if (ov !== e[33]) begin
      bad++;
      $display("FAIL %s_ov: got ov=%0b, expected ov=%0b", nm, ov, e[33]);
    end
`endif
  endtask

  task automatic drive(input logic [31:0] ta, input logic [31:0] tb_v, input logic tci,
                       input logic [33:0] e, input string nm);
    a  = ta;
    b  = tb_v;
    ci = tci;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // One cycle: compare the result due now, then apply the next operands.
  task automatic step(input logic [31:0] ta, input logic [31:0] tb_v, input logic tci,
                      input logic [33:0] e, input string nm);
    @(negedge clk);
    if (exp_q.size() >= 2) check_out(name_q.pop_front(), exp_q.pop_front());
    drive(ta, tb_v, tci, e, nm);
  endtask

  task automatic rstep(input logic [31:0] ta, input logic [31:0] tb_v, input logic tci,
                       input string nm);
    step(ta, tb_v, tci, ref_add(ta, tb_v, tci), nm);
  endtask

  // ---------------- test ----------------
  initial begin
    logic [31:0] ra, rb;
    logic        rci;

    vecs[0] = '{32'd38297,     32'd126625,   1'b0, 32'd164922,   1'b0, 1'b0, "t2_a"};
    vecs[1] = '{32'd376173,    32'd421542,   1'b0, 32'd797715,   1'b0, 1'b0, "t2_b"};
    vecs[2] = '{32'd100,       32'd100,      1'b1, 32'd201,      1'b0, 1'b0, "t2_c"};
    vecs[3] = '{32'hFFFFFFFF,  32'd1,        1'b0, 32'h0,        1'b1, 1'b0, "t3_max_p1"};
    vecs[4] = '{32'h0,         32'hFFFFFFFF, 1'b1, 32'h0,        1'b1, 1'b0, "t3_ci_wrap"};
    vecs[5] = '{32'hFFFFFFFF,  32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, "t3_all_ones"};
    vecs[6] = '{32'hFFFFFFFF,  32'h0,        1'b1, 32'h0,        1'b1, 1'b0, "t3_max_ci"};
    vecs[7] = '{32'd2147151326, 32'd332321,  1'b0, 32'h7FFFFFFF, 1'b0, 1'b0, "t4_no_ov"};
    vecs[8] = '{32'h7FFFFFFF,  32'd1,        1'b0, 32'h80000000, 1'b0, 1'b1, "t4_pos_ov"};
    vecs[9] = '{32'h80000000,  32'h80000000, 1'b0, 32'h0,        1'b1, 1'b1, "t4_neg_ov"};

    reset_n = 1'b0;
    a = '0; b = '0; ci = 1'b0;
    #1;
    check_out("reset_async", 34'h0);
    a = 32'h12345678; b = 32'h9ABCDEF0; ci = 1'b1;
    repeat (3) @(negedge clk);
    check_out("reset_held", 34'h0);

    // Release: output stays 0 for this cycle and the next, then test 1 appears.
    reset_n = 1'b1;
    exp_q.delete();
    name_q.delete();
    exp_q.push_back(34'h0);
    name_q.push_back("post_reset");
    drive(32'h0, 32'h0, 1'b0, 34'h0, "t1_zero");

    for (int i = 0; i < 10; i++)
      step(vecs[i].a, vecs[i].b, vecs[i].ci,
           {vecs[i].ov, vecs[i].co, vecs[i].s}, vecs[i].name);

    for (int i = 0; i < 10000; i++) begin
      case ($urandom_range(0, 7))
        0:       ra = 32'hFFFFFFFF;
        1:       ra = 32'h7FFFFFFF + $urandom_range(0, 2);
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       rb = ~ra;
        1:       rb = 32'h80000000;
        default: rb = $urandom;
      endcase
      rci = 1'($urandom_range(0, 1));
      rstep(ra, rb, rci, "rand");
    end

    // Mid-stream reset between edges: in-flight results are discarded.
    rstep(32'hDEADBEEF, 32'h11111111, 1'b1, "pre_rst_a");
    rstep(32'h0F0F0F0F, 32'hF0F0F0F0, 1'b1, "pre_rst_b");
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_out("midrst_async", 34'h0);
    exp_q.delete();
    name_q.delete();
    a = 32'h00010001; b = 32'h00020002; ci = 1'b1;
    @(negedge clk);
    check_out("midrst_held", 34'h0);
    reset_n = 1'b1;
    check_out("midrst_release", 34'h0);
    exp_q.push_back(34'h0);
    name_q.push_back("midrst_post1");
    drive(32'h00010001, 32'h00020002, 1'b1, {2'b00, 32'h00030004}, "midrst_post2");
    step(32'h00010001, 32'h00020002, 1'b1, {2'b00, 32'h00030004}, "midrst_held_in");
    step(32'h00010001, 32'h00020002, 1'b1, {2'b00, 32'h00030004}, "midrst_held_in");

    rstep(32'h0, 32'h0, 1'b0, "flush");
    rstep(32'h0, 32'h0, 1'b0, "flush");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
